// File: rtl/mem_resp_if.sv
// Handshake/bus bundle for mem_resp: two read ports, one write port, ready.
// Master drives addresses and write data; slave returns read data and ready.
interface mem_resp_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] raddr0;
    logic [DATA_W-1:0] rdata0;
    logic [ADDR_W-1:0] raddr1;
    logic [DATA_W-1:0] rdata1;
    logic              wen;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              ready;

    modport master (
        output raddr0,
        output raddr1,
        output wen,
        output waddr,
        output wdata,
        input  rdata0,
        input  rdata1,
        input  ready
    );

    modport slave (
        input  raddr0,
        input  raddr1,
        input  wen,
        input  waddr,
        input  wdata,
        output rdata0,
        output rdata1,
        output ready
    );
endinterface

// File: rtl/mem_resp.sv
// Dual-read, single-write word memory that self-clears after reset.
// MEM_RESP_WR_FWD_EN selects write-first forwarding (default read-first).
module mem_resp #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 16
) (
    input logic       clk,
    input logic       rst_n,
    mem_resp_if.slave bus
);
    typedef enum logic {
        INIT,
        RUN
    } state_t;

    localparam logic [ADDR_W-1:0] LAST = '1;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] cnt_nxt;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_wa;
    logic [DATA_W-1:0] mem_wd;

    logic              fwd0;
    logic              fwd1;
    logic [DATA_W-1:0] rd0_nxt;
    logic [DATA_W-1:0] rd1_nxt;
    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata1_q;

    logic [DATA_W-1:0] mem [2**ADDR_W];

`ifdef MEM_RESP_WR_FWD_EN
    assign fwd0 = (state == RUN) && bus.wen
                  && (bus.raddr0 == bus.waddr);
    assign fwd1 = (state == RUN) && bus.wen
                  && (bus.raddr1 == bus.waddr);
`else
    assign fwd0 = 1'b0;
    assign fwd1 = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= INIT;
            cnt      <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            rdata0_q <= rd0_nxt;
            rdata1_q <= rd1_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        mem_we    = 1'b0;
        mem_wa    = cnt;
        mem_wd    = '0;
        rd0_nxt   = '0;
        rd1_nxt   = '0;
        unique case (state)
            INIT: begin
                // Sweep every word to zero; wrap and leave on the last one.
                mem_we  = 1'b1;
                cnt_nxt = cnt + 1'b1;
                if (cnt == LAST) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                mem_we  = bus.wen;
                mem_wa  = bus.waddr;
                mem_wd  = bus.wdata;
                rd0_nxt = fwd0 ? bus.wdata : mem[bus.raddr0];
                rd1_nxt = fwd1 ? bus.wdata : mem[bus.raddr1];
            end
        endcase
    end

    // Storage is never reset; INIT clears it after release instead.
    always_ff @(posedge clk) begin
        if (rst_n && mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
    end

    assign bus.rdata0 = rdata0_q;
    assign bus.rdata1 = rdata1_q;
    assign bus.ready  = (state == RUN);
endmodule

// File: tb/tb_mem_resp.sv
// Directed self-checking bench for mem_resp at ADDR_W=4, DATA_W=16.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mem_resp;
    localparam int AW = 4;
    localparam int DW = 16;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    mem_resp_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_resp #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic write_word(input logic [AW-1:0] a,
                              input logic [DW-1:0] d);
        bus.wen   = 1'b1;
        bus.waddr = a;
        bus.wdata = d;
        step();
        bus.wen   = 1'b0;
    endtask

    // Expects rst_n already low; releases it and walks the 16-edge clear.
    task automatic init_seq(input string tag, input bit init_wr);
        step();
        checks++;
        if (bus.ready !== 1'b0 || bus.rdata0 !== '0 || bus.rdata1 !== '0) begin
            errors++;
            $display("FAIL %s_in_reset ready=%b rd0=%h rd1=%h want 0/0/0",
                     tag, bus.ready, bus.rdata0, bus.rdata1);
        end
        bus.raddr0 = 4'd5;
        if (init_wr) begin
            bus.wen   = 1'b1;
            bus.waddr = 4'd2;
            bus.wdata = 16'hAAAA;
        end
        rst_n = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            step();
            if (i < 16) begin
                checks++;
                if (bus.ready !== 1'b0 || bus.rdata0 !== '0) begin
                    errors++;
                    $display("FAIL %s_init_edge%0d ready=%b rd0=%h want 0/0000",
                             tag, i, bus.ready, bus.rdata0);
                end
            end else begin
                checks++;
                if (bus.ready !== 1'b1) begin
                    errors++;
                    $display("FAIL %s_ready_edge16 ready=%b want 1",
                             tag, bus.ready);
                end
            end
        end
        bus.wen = 1'b0;
        step();
        checks++;
        if (bus.rdata0 !== 16'h0000 || bus.ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_first_run_read rd0=%h ready=%b want 0000/1",
                     tag, bus.rdata0, bus.ready);
        end
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        bus.raddr0 = '0;
        bus.raddr1 = '0;
        bus.wen    = 1'b0;
        bus.waddr  = '0;
        bus.wdata  = '0;
        step();
        init_seq("reset", 1'b1);
    endtask

    task automatic test_init_write();
        bus.raddr0 = 4'd2;
        bus.raddr1 = 4'd2;
        step();
        checks++;
        if (bus.rdata0 !== 16'h0000 || bus.rdata1 !== 16'h0000) begin
            errors++;
            $display("FAIL init_write_ignored rd0=%h rd1=%h want 0000",
                     bus.rdata0, bus.rdata1);
        end
    endtask

    task automatic test_write_read();
        write_word(4'd3, 16'hBEEF);
        write_word(4'd4, 16'h5A5A);
        bus.raddr0 = 4'd3;
        bus.raddr1 = 4'd3;
        step();
        checks++;
        if (bus.rdata0 !== 16'hBEEF || bus.rdata1 !== 16'hBEEF) begin
            errors++;
            $display("FAIL same_addr_read rd0=%h rd1=%h want beef/beef",
                     bus.rdata0, bus.rdata1);
        end
        bus.raddr0 = 4'd4;
        bus.raddr1 = 4'd3;
        step();
        checks++;
        if (bus.rdata0 !== 16'h5A5A || bus.rdata1 !== 16'hBEEF) begin
            errors++;
            $display("FAIL indep_ports rd0=%h rd1=%h want 5a5a/beef",
                     bus.rdata0, bus.rdata1);
        end
    endtask

    task automatic test_same_edge();
        logic [DW-1:0] exp_first;
`ifdef MEM_RESP_WR_FWD_EN
        exp_first = 16'h2222;
`else
        exp_first = 16'h1111;
`endif
        write_word(4'd7, 16'h1111);
        bus.raddr0 = 4'd7;
        bus.raddr1 = 4'd7;
        write_word(4'd7, 16'h2222);
        checks++;
        if (bus.rdata0 !== exp_first || bus.rdata1 !== exp_first) begin
            errors++;
            $display("FAIL same_edge_rw rd0=%h rd1=%h want %h",
                     bus.rdata0, bus.rdata1, exp_first);
        end
        step();
        checks++;
        if (bus.rdata0 !== 16'h2222 || bus.rdata1 !== 16'h2222) begin
            errors++;
            $display("FAIL same_edge_after rd0=%h rd1=%h want 2222",
                     bus.rdata0, bus.rdata1);
        end
    endtask

    task automatic test_back_to_back();
        bus.raddr0 = 4'd15;
        bus.raddr1 = 4'd15;
        for (int i = 0; i < 16; i++) begin
            bus.wen   = 1'b1;
            bus.waddr = AW'(i);
            bus.wdata = DW'(i + 1);
            step();
        end
        bus.wen = 1'b0;
        for (int i = 0; i < 16; i++) begin
            bus.raddr0 = AW'(i);
            bus.raddr1 = AW'(15 - i);
            step();
            checks++;
            if (bus.rdata0 !== DW'(i + 1) || bus.rdata1 !== DW'(16 - i)) begin
                errors++;
                $display("FAIL b2b_read%0d rd0=%h rd1=%h want %h/%h",
                         i, bus.rdata0, bus.rdata1, DW'(i + 1), DW'(16 - i));
            end
        end
    endtask

    task automatic test_mid_reset();
        write_word(4'd9, 16'h1234);
        bus.raddr0 = 4'd9;
        bus.raddr1 = 4'd9;
        step();
        checks++;
        if (bus.rdata0 !== 16'h1234 || bus.rdata1 !== 16'h1234) begin
            errors++;
            $display("FAIL pre_reset_read rd0=%h rd1=%h want 1234",
                     bus.rdata0, bus.rdata1);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.ready !== 1'b0 || bus.rdata0 !== '0 || bus.rdata1 !== '0) begin
            errors++;
            $display("FAIL async_reset ready=%b rd0=%h rd1=%h want 0/0/0",
                     bus.ready, bus.rdata0, bus.rdata1);
        end
        bus.wen   = 1'b1;
        bus.waddr = 4'd9;
        bus.wdata = 16'hFFFF;
        step();
        bus.wen = 1'b0;
        init_seq("midreset", 1'b0);
        bus.raddr0 = 4'd9;
        bus.raddr1 = 4'd3;
        step();
        checks++;
        if (bus.rdata0 !== 16'h0000 || bus.rdata1 !== 16'h0000) begin
            errors++;
            $display("FAIL post_reset_clear rd0=%h rd1=%h want 0000",
                     bus.rdata0, bus.rdata1);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_init_write();
        test_write_read();
        test_same_edge();
        test_back_to_back();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_resp.md
MEM_RESP -- requirements
Module: mem_resp

Interface
REQ-001 SHALL have parameter ADDR_W, default 15, word-address width (depth = 2^ADDR_W words).
REQ-002 SHALL have parameter DATA_W, default 16, data word width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port raddr0  input  ADDR_W  read port 0 word address (instruction fetch).
REQ-006 SHALL have port rdata0  output  DATA_W  read port 0 data, registered.
REQ-007 SHALL have port raddr1  input  ADDR_W  read port 1 word address (data load).
REQ-008 SHALL have port rdata1  output  DATA_W  read port 1 data, registered.
REQ-009 SHALL have port wen  input  1  write enable.
REQ-010 SHALL have port waddr  input  ADDR_W  write word address.
REQ-011 SHALL have port wdata  input  DATA_W  write data.
REQ-012 SHALL have port ready  output  1  high when the memory accepts reads and writes.

Function
REQ-013 SHALL implement a two-state FSM: INIT (clearing) and RUN (serving).
REQ-014 In INIT, each rising edge SHALL write 0 to mem[cnt] and increment the ADDR_W-bit counter cnt.
REQ-015 INIT->RUN SHALL occur on the edge that clears address 2^ADDR_W-1; ready rises on that same edge, i.e. the 2^ADDR_W-th edge after rst_n release.
REQ-016 RUN SHALL be held until reset; no other transition exists.
REQ-017 In INIT, rdata0 and rdata1 SHALL be driven 0 and wen SHALL be ignored.
REQ-018 In RUN, rdataN SHALL equal mem[raddrN] as sampled at the previous rising edge (latency 1).
REQ-019 Ports 0 and 1 SHALL be independent; equal addresses SHALL return identical data.
REQ-020 In RUN, with wen=1, mem[waddr] SHALL take wdata at the rising edge.
REQ-021 Addresses SHALL be exactly ADDR_W bits; no out-of-range case exists, and cnt wraps only on the INIT exit edge.
REQ-022 Same-edge write and read of the same address SHALL follow REQ-030/REQ-031.
REQ-023 Writes to different addresses on consecutive cycles SHALL all take effect; no write is dropped in RUN.

Reset
REQ-024 rst_n low SHALL asynchronously force state=INIT, cnt=0, ready=0, rdata0=0, rdata1=0.
REQ-025 Memory contents SHALL NOT be cleared asynchronously; clearing occurs via INIT after release.
REQ-026 Reset asserted mid-INIT or mid-RUN SHALL restart the full clear sequence from address 0.
REQ-027 A write presented on the edge where rst_n is low SHALL be discarded.

Configuration
REQ-028 Macro MEM_RESP_WR_FWD_EN SHALL select write-to-read forwarding.
REQ-029 Forwarding applies only in RUN when wen=1 and raddrN==waddr on the same edge.
REQ-030 With MEM_RESP_WR_FWD_EN defined, rdataN on the next cycle SHALL equal wdata (write-first).
REQ-031 Without it, rdataN on the next cycle SHALL equal the pre-write content (read-first); the new value is visible from the following read.

Verification (ADDR_W=4, DATA_W=16)
REQ-032 Release rst_n, raddr0=5 -> ready=0 and rdata0=0 for edges 1-15; ready=1 after edge 16; rdata0=0x0000 one cycle after first RUN edge.
REQ-033 RUN: write 0xBEEF@3, then raddr0=3, raddr1=3 -> both rdata0 and rdata1 = 0xBEEF one cycle later.
REQ-034 RUN: mem[7]=0x1111; same edge wen=1 waddr=7 wdata=0x2222, raddr1=7 -> rdata1=0x2222 with MEM_RESP_WR_FWD_EN, 0x1111 without; next read 0x2222 in both builds.
REQ-035 During INIT: wen=1 waddr=2 wdata=0xAAAA -> after ready, read 2 returns 0x0000.
REQ-036 RUN: mem[9]=0x1234; pulse rst_n low mid-cycle -> rdata0, rdata1, ready = 0 immediately; after 16 edges ready=1, read 9 returns 0x0000.
REQ-037 RUN: back-to-back writes 0x0001..0x0010 to addresses 0..15, then sequential reads 0..15 -> data 0x0001..0x0010 in order, one per cycle, latency 1.
